// File: rtl/snapshot_memory_bank_if.sv
// snapshot_memory_bank_if
//   Bus bundle for the snapshot memory bank: write side (clr, wren, din),
//   pop side (rd_en -> rd_data/rd_valid), and status (dout, count, full,
//   empty, ovf). clk and arst are kept outside the bundle.
//
//   Pop handshake: the requester raises rd_en for one or more cycles. Each
//   edge where rd_en=1, clr=0 and the queue is not empty pops exactly one
//   word. rd_valid is high for the cycle after that edge, and rd_data is
//   meaningful only while rd_valid is high. There is no back-pressure on
//   the returned data. A rd_en on an empty queue is dropped silently.
//
//   Modports:
//     master : supervisor / driver side (drives clr, wren, din, rd_en)
//     slave  : memory bank side (drives dout, rd_data, rd_valid, status)
interface snapshot_memory_bank_if #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clr;
  logic             wren;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf;

  modport master (
    output clr, wren, din, rd_en,
    input  dout, rd_data, rd_valid, count, full, empty, ovf
  );

  modport slave (
    input  clr, wren, din, rd_en,
    output dout, rd_data, rd_valid, count, full, empty, ovf
  );
endinterface

// File: rtl/snapshot_memory_bank.sv
// snapshot_memory_bank
//   Live status register plus a DEPTH-entry FIFO history of written words.
//   Every wren updates the live register (dout). The same write is also
//   queued as a snapshot unless the queue is full, in which case OVERWRITE
//   selects between dropping the oldest entry (1) and rejecting the new one
//   (0); both cases set the sticky ovf flag. The supervisor drains the queue
//   through a registered pop port with one cycle of latency.
//
//   Ports:
//     clk   : clock, rising edge
//     arst  : asynchronous reset, active low
//     bus   : snapshot_memory_bank_if.slave
//             clr, wren, din, rd_en           (in)
//             dout, rd_data, rd_valid, count,
//             full, empty, ovf                (out)
//
//   Parameters:
//     WIDTH     : bits per status word
//     DEPTH     : history entries, >= 2, any integer
//     OVERWRITE : 1 = full write drops oldest, 0 = full write is discarded
module snapshot_memory_bank #(
  parameter int WIDTH     = 35,
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  snapshot_memory_bank_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
  localparam logic          OW_EN      = (OVERWRITE != 0);

  // Storage and registered state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;

  // Next-state decode
  logic             is_full;
  logic             is_empty;
  logic             do_pop;
  logic             do_push;
  logic             do_drop;
  logic             ovf_set;
  logic [CW-1:0]    count_nxt;
  logic [PW-1:0]    wptr_nxt;
  logic [PW-1:0]    rptr_nxt;

  // Pointers wrap at DEPTH-1 explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign is_full  = (count_q == COUNT_FULL);
  assign is_empty = (count_q == '0);

  always_comb begin
    do_pop    = 1'b0;
    do_push   = 1'b0;
    do_drop   = 1'b0;
    ovf_set   = 1'b0;
    count_nxt = count_q;
    wptr_nxt  = wptr_q;
    rptr_nxt  = rptr_q;

    if (bus.clr) begin
      count_nxt = '0;
      wptr_nxt  = '0;
      rptr_nxt  = '0;
    end else begin
      // A pop on an empty queue is ignored even if a push lands on the same
      // edge: there is no write-to-read bypass.
      do_pop = bus.rd_en && !is_empty;

      // A simultaneous pop frees a slot, so a full queue still accepts the
      // write without counting it as an overflow.
      if (bus.wren) begin
        if (!is_full || do_pop) begin
          do_push = 1'b1;
        end else begin
          ovf_set = 1'b1;
          if (OW_EN) begin
            do_push = 1'b1;
            do_drop = 1'b1;
          end
        end
      end

      if (do_push) begin
        wptr_nxt = ptr_inc(wptr_q);
      end
      // Dropping the oldest entry moves the read pointer just like a pop,
      // but nothing is returned on the read port.
      if (do_pop || do_drop) begin
        rptr_nxt = ptr_inc(rptr_q);
      end

      // Drop+push leaves the count at DEPTH; pop+push leaves it unchanged.
      if (do_push && !do_pop && !do_drop) begin
        count_nxt = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_nxt = count_q - CW'(1);
      end
    end
  end

  // Live register: tracks every write, independent of queue state or clr.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      dout_q <= '0;
    end else if (bus.wren) begin
      dout_q <= bus.din;
    end
  end

  // Queue bookkeeping
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      wptr_q  <= wptr_nxt;
      rptr_q  <= rptr_nxt;
      if (bus.clr) begin
        ovf_q <= 1'b0;
      end else if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Read port. When a full queue pops and pushes on the same edge,
  // rptr == wptr; the read below samples the old word before the write
  // replaces it, which keeps ordering strictly FIFO.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_pop;
      if (do_pop) begin
        rd_data_q <= mem[rptr_q];
      end
    end
  end

  // Storage array has no reset so it can map onto plain RAM; the pointers
  // and count guarantee stale words are never returned.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= bus.din;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_snapshot_memory_bank.sv
// tb_snapshot_memory_bank
//   Three instances share one stimulus stream:
//     u0: DEPTH=8, OVERWRITE=1
//     u1: DEPTH=8, OVERWRITE=0
//     u2: DEPTH=5, OVERWRITE=1
//   A queue-based reference model per instance predicts status outputs;
//   popped words are pushed to exp_q when the pop is driven and compared
//   when rd_valid appears.
module tb_snapshot_memory_bank;

  localparam int W = 35;
  localparam int N = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  // Shared stimulus
  logic         clr;
  logic         wren;
  logic         rd_en;
  logic [W-1:0] din;

  snapshot_memory_bank_if #(.WIDTH(W), .DEPTH(8)) bus_0 ();
  snapshot_memory_bank_if #(.WIDTH(W), .DEPTH(8)) bus_1 ();
  snapshot_memory_bank_if #(.WIDTH(W), .DEPTH(5)) bus_2 ();

  assign bus_0.clr = clr;  assign bus_0.wren = wren;
  assign bus_0.din = din;  assign bus_0.rd_en = rd_en;
  assign bus_1.clr = clr;  assign bus_1.wren = wren;
  assign bus_1.din = din;  assign bus_1.rd_en = rd_en;
  assign bus_2.clr = clr;  assign bus_2.wren = wren;
  assign bus_2.din = din;  assign bus_2.rd_en = rd_en;

  snapshot_memory_bank #(.WIDTH(W), .DEPTH(8), .OVERWRITE(1)) u0 (
    .clk(clk), .arst(arst), .bus(bus_0)
  );
  snapshot_memory_bank #(.WIDTH(W), .DEPTH(8), .OVERWRITE(0)) u1 (
    .clk(clk), .arst(arst), .bus(bus_1)
  );
  snapshot_memory_bank #(.WIDTH(W), .DEPTH(5), .OVERWRITE(1)) u2 (
    .clk(clk), .arst(arst), .bus(bus_2)
  );

  // Observed outputs gathered per instance
  logic [W-1:0] rd  [N];
  logic [W-1:0] dq  [N];
  logic [3:0]   cnt [N];
  logic [N-1:0] rv, fl, em, ov;

  assign rd[0] = bus_0.rd_data; assign rd[1] = bus_1.rd_data; assign rd[2] = bus_2.rd_data;
  assign dq[0] = bus_0.dout;    assign dq[1] = bus_1.dout;    assign dq[2] = bus_2.dout;
  assign cnt[0] = bus_0.count;  assign cnt[1] = bus_1.count;  assign cnt[2] = {1'b0, bus_2.count};
  assign rv = {bus_2.rd_valid, bus_1.rd_valid, bus_0.rd_valid};
  assign fl = {bus_2.full,     bus_1.full,     bus_0.full};
  assign em = {bus_2.empty,    bus_1.empty,    bus_0.empty};
  assign ov = {bus_2.ovf,      bus_1.ovf,      bus_0.ovf};

  // Reference model
  int           depth_m [N] = '{8, 8, 5};
  bit           ow_m    [N] = '{1'b1, 1'b0, 1'b1};
  logic [W-1:0] mq      [N][$];
  logic [W-1:0] exp_q   [N][$];
  bit           m_ovf   [N];
  bit           m_rv    [N];
  logic [W-1:0] m_rd    [N];
  logic [W-1:0] m_dout;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      exp_q[i].delete();
      m_ovf[i] = 1'b0;
      m_rv[i]  = 1'b0;
      m_rd[i]  = '0;
    end
    m_dout = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    logic [W-1:0] tmp;
    bit pop, was_full;
    if (wren) m_dout = din;
    for (int i = 0; i < N; i++) begin
      m_rv[i] = 1'b0;
      if (clr) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
      end else begin
        pop      = rd_en && (mq[i].size() > 0);
        was_full = (mq[i].size() == depth_m[i]);
        if (pop) begin
          exp_q[i].push_back(mq[i].pop_front());
          m_rv[i] = 1'b1;
        end
        if (wren) begin
          if (!was_full || pop) begin
            mq[i].push_back(din);
          end else begin
            m_ovf[i] = 1'b1;
            if (ow_m[i]) begin
              tmp = mq[i].pop_front();
              mq[i].push_back(din);
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d.count", i), W'(cnt[i]), W'(mq[i].size()));
      check($sformatf("u%0d.full", i), W'(fl[i]), W'(mq[i].size() == depth_m[i]));
      check($sformatf("u%0d.empty", i), W'(em[i]), W'(mq[i].size() == 0));
      check($sformatf("u%0d.ovf", i), W'(ov[i]), W'(m_ovf[i]));
      check($sformatf("u%0d.dout", i), dq[i], m_dout);
      check($sformatf("u%0d.rd_valid", i), W'(rv[i]), W'(m_rv[i]));
      if (m_rv[i] && exp_q[i].size() > 0) m_rd[i] = exp_q[i].pop_front();
      check($sformatf("u%0d.rd_data", i), rd[i], m_rd[i]);
    end
  endtask

  // Driver tasks
  task automatic drive(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    wren  = w;
    din   = d;
    rd_en = r;
    clr   = c;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge.
  task automatic mid_reset(input string tag);
    drive(0, '0, 0, 0);
    @(negedge clk);
    #2 arst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.u%0d.count", tag, i), W'(cnt[i]), '0);
      check($sformatf("%s.u%0d.empty", tag, i), W'(em[i]), W'(1));
      check($sformatf("%s.u%0d.full", tag, i), W'(fl[i]), '0);
      check($sformatf("%s.u%0d.ovf", tag, i), W'(ov[i]), '0);
      check($sformatf("%s.u%0d.rd_valid", tag, i), W'(rv[i]), '0);
      check($sformatf("%s.u%0d.rd_data", tag, i), rd[i], '0);
      check($sformatf("%s.u%0d.dout", tag, i), dq[i], '0);
    end
    @(posedge clk);
    @(negedge clk);
    #2 arst = 1'b1;
  endtask

  initial begin
    arst = 1'b0;
    drive(0, '0, 0, 0);
    model_reset();

    // 1. reset / idle
    @(posedge clk);
    mid_reset("t1");
    tick();

    // 2. fill and drain
    for (int k = 1; k <= 8; k++) begin drive(1, W'(k), 0, 0); tick(); end
    check("t2.full_after_8", W'(fl[0]), W'(1));
    for (int k = 0; k < 8; k++) begin drive(0, '0, 1, 0); tick(); end
    drive(0, '0, 0, 0); tick();
    check("t2.empty_end", W'(em[0]), W'(1));
    check("t2.dout_hold", dq[0], W'(8));

    // 3. overflow policies; leave a read in flight when reset hits
    mid_reset("t3");
    for (int k = 1; k <= 10; k++) begin drive(1, W'(k), 0, 0); tick(); end
    check("t3.u0_ovf", W'(ov[0]), W'(1));
    check("t3.u1_ovf", W'(ov[1]), W'(1));
    for (int k = 0; k < 8; k++) begin drive(0, '0, 1, 0); tick(); end
    check("t3.u0_last", rd[0], W'(10));
    check("t3.u1_last", rd[1], W'(8));
    for (int k = 1; k <= 3; k++) begin drive(1, W'(k), 0, 0); tick(); end
    drive(0, '0, 1, 0); tick();

    // 4. simultaneous push and pop
    mid_reset("t4");
    for (int k = 1; k <= 8; k++) begin drive(1, W'(k), 0, 0); tick(); end
    drive(1, W'(9), 1, 0); tick();
    check("t4.u0_rd_first", rd[0], W'(1));
    check("t4.u0_ovf_clear", W'(ov[0]), '0);
    for (int k = 0; k < 8; k++) begin drive(0, '0, 1, 0); tick(); end
    check("t4.u0_last", rd[0], W'(9));
    drive(1, W'(35'h55), 1, 0); tick();
    check("t4.u0_empty_rv", W'(rv[0]), '0);
    check("t4.u0_empty_cnt", W'(cnt[0]), W'(1));
    drive(0, '0, 1, 0); tick();
    drive(0, '0, 0, 0); tick();

    // 5. wrap, then clear with a concurrent write
    for (int k = 1; k <= 5; k++) begin drive(1, W'(k + 16), 0, 0); tick(); end
    for (int k = 0; k < 5; k++) begin drive(0, '0, 1, 0); tick(); end
    for (int k = 1; k <= 6; k++) begin drive(1, W'(k + 32), 0, 0); tick(); end
    drive(1, W'(35'h7FF), 0, 1); tick();
    check("t5.dout_7ff", dq[0], W'(35'h7FF));
    check("t5.empty", W'(em[0]), W'(1));
    drive(0, '0, 1, 0); tick();
    check("t5.rv_after_clr", W'(rv[0]), '0);

    // 6. non-power-of-two depth (u2)
    mid_reset("t6");
    for (int k = 1; k <= 7; k++) begin drive(1, W'(k), 0, 0); tick(); end
    for (int k = 0; k < 7; k++) begin drive(0, '0, 1, 0); tick(); end
    check("t6.u2_last", rd[2], W'(7));
    check("t6.u2_count", W'(cnt[2]), '0);

    // Random traffic with occasional clears and a final reset mid-read
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 99) < 60, W'({$urandom(), $urandom()}),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
      tick();
    end
    drive(1, W'(35'h123), 0, 0); tick();
    drive(0, '0, 1, 0); tick();
    mid_reset("tend");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snapshot_memory_bank.md
Name: snapshot_memory_bank

Overview:
- Parametrised successor to the single-word 35-bit memory unit of the smart-home controller.
- Keeps a live register of the most recent status word, like the existing unit.
- Adds a DEPTH-entry history queue of written snapshots, drained by the supervisor through a registered read port.
- Reports occupancy and overflow, and offers a selectable policy for writes that arrive when the queue is full.

Parameters:
- WIDTH, 35: bits per status word.
- DEPTH, 8: history entries; any integer >= 2, not required to be a power of two.
- OVERWRITE, 1: full-queue write policy. 1 = drop the oldest entry and store the new one; 0 = reject the new entry.

Ports:
- clk  in  1  clock, posedge.
- arst  in  1  asynchronous reset, active-low. arst=0 resets immediately; release is independent of clk.
- clr  in  1  synchronous clear of the queue and the overflow flag.
- wren  in  1  write enable; captures din.
- din  in  WIDTH  input status word.
- dout  out  WIDTH  live register, last value written.
- rd_en  in  1  pop request.
- rd_data  out  WIDTH  popped word, registered.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while high.
- count  out  $clog2(DEPTH+1)  stored entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (arst=0, asynchronous):
  - dout, rd_data, rd_valid, count and ovf go to 0, and empty goes to 1.
  - Write and read pointers go to 0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all entries and any read in flight; the rd_valid pulse is suppressed.
- All other state changes occur on the clk posedge only. full, empty and count are registered (or decoded from registered count) and reflect the state after the edge.
- Live register: on wren=1, dout<=din on the next edge, regardless of full, OVERWRITE or clr.
- Push (wren=1 and not full): mem[wptr]<=din; wptr advances; count+1.
- Pop (rd_en=1 and not empty):
  - rd_data<=mem[rptr] and rd_valid=1 on the next cycle; rptr advances; count-1.
  - Read latency is 1 cycle.
  - rd_en while empty is ignored: rd_valid=0 and rd_data holds its last value. There is no underflow flag.
- Pointer wrap: each pointer goes from DEPTH-1 to 0.
- Simultaneous push and pop, when not empty:
  - Both happen and count is unchanged.
  - When full, the pop frees the slot: the write is stored, ovf is not set, and no entry is dropped.
- Simultaneous push and pop when empty: the pop is ignored (no bypass); the push is stored; count becomes 1.
- Write when full with no pop:
  - OVERWRITE=1: mem[wptr]<=din, and wptr and rptr both advance, so the oldest entry is lost. count stays DEPTH; ovf<=1.
  - OVERWRITE=0: the write is discarded; pointers and count are unchanged; ovf<=1.
- ovf is sticky until clr or reset.
- clr=1:
  - Next edge: pointers and count go to 0, ovf to 0, rd_valid to 0.
  - clr has priority over wren and rd_en for the queue, but dout still updates when wren=1.
  - rd_data holds.
- A returned value always precedes later writes: ordering is strictly FIFO.

Test Plan:
1. Reset/idle:
   - Stimulus: hold arst=0 mid-clock, then release.
   - Required: dout=0, count=0, empty=1, full=0, ovf=0, rd_valid=0; arst asserted between edges clears outputs without waiting for a clock.
2. Fill and drain, DEPTH=8:
   - Stimulus: write 35'h1..35'h8, then pop 8 times.
   - Required: full=1 after the 8th write; rd_data is 1..8 in order, each with rd_valid exactly one cycle after rd_en; empty=1 at the end; dout=35'h8 throughout the drain.
3. Overflow, OVERWRITE=1:
   - Stimulus: write 1..10, then pop 8 times.
   - Required: ovf=1 after the 9th write; count stays 8; pops return 3..10.
   - Rerun with OVERWRITE=0: pops return 1..8 and ovf=1.
4. Simultaneous operations:
   - Stimulus: with the queue full of 1..8, assert wren=1 (din=35'h9) and rd_en=1 together.
   - Required: rd_data=1; count=8; ovf stays 0; the last pop returns 9.
   - Stimulus: on an empty queue, wren+rd_en together.
   - Required: rd_valid=0, count=1.
5. Clear and wrap:
   - Stimulus: write 5, pop 5, write 6 (pointers wrap), then clr=1 with wren=1 din=35'h7FF.
   - Required: count=0, empty=1, ovf=0, dout=35'h7FF.
   - Stimulus: a subsequent rd_en.
   - Required: rd_valid=0.
6. Non-power-of-two:
   - Stimulus: DEPTH=5; write 1..7 with OVERWRITE=1, then drain.
   - Required: pops return 3..7; count reaches 0; no X on rd_data.
